// File: rtl/ser_to_par_rx.sv
// ser_to_par_rx: serial-to-parallel frame receiver.
// Frame = start bit (0), WIDTH data bits, optional even-parity bit, stop bit (1).
// One bit is sampled per clock edge with ENABLE=1; the received word is held on
// OUT under a VALID/READY handshake, and framing/overrun errors pulse for one cycle.
// Optional feature macro: SER_RX_PARITY_CHECK_EN (adds an even-parity bit after the data).
module ser_to_par_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic             SIN,
  output logic [WIDTH-1:0] OUT,
  output logic             VALID,
  input  logic             READY,
  output logic             FRAME_ERR,
  output logic             OVERRUN,
  output logic             BUSY
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
`ifdef SER_RX_PARITY_CHECK_EN
    PARITY    = 3'd2,
`endif
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] shift, shift_next;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             valid, valid_next;
  logic             frame_err, frame_err_next;
  logic             overrun, overrun_next;

  // Shift direction decides whether the first data bit ends up in the MSB or LSB.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_in = {shift[WIDTH-2:0], SIN};
    end else begin : g_lsb_first
      assign shift_in = {SIN, shift[WIDTH-1:1]};
    end
  endgenerate

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      cnt       <= '0;
      shift     <= '0;
      out_reg   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      shift     <= shift_next;
      out_reg   <= out_next;
      valid     <= valid_next;
      frame_err <= frame_err_next;
      overrun   <= overrun_next;
    end
  end

  // Next-state logic: handshake runs every cycle, the frame FSM only on enabled edges.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    shift_next     = shift;
    out_next       = out_reg;
    valid_next     = valid;
    frame_err_next = 1'b0;
    overrun_next   = 1'b0;

    // Consumer take is independent of the bit strobe.
    if (valid && READY) begin
      valid_next = 1'b0;
    end

    if (ENABLE) begin
      case (state)
        IDLE: begin
          if (!SIN) begin
            state_next = DATA;
            cnt_next   = '0;
          end
        end
        DATA: begin
          shift_next = shift_in;
          if (cnt == LAST_BIT) begin
            cnt_next = '0;
`ifdef SER_RX_PARITY_CHECK_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
`ifdef SER_RX_PARITY_CHECK_EN
        PARITY: begin
          // Even parity: data ones plus parity bit must be even.
          if (SIN != (^shift)) begin
            frame_err_next = 1'b1;
            state_next     = WAIT_IDLE;
          end else begin
            state_next = STOP;
          end
        end
`endif
        STOP: begin
          if (SIN) begin
            state_next = IDLE;
            // A word can land if the holder is empty or being emptied this very edge.
            if (!valid || READY) begin
              out_next   = shift;
              valid_next = 1'b1;
            end else begin
              overrun_next = 1'b1;
            end
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          // Hold off start detection until the line returns high (break guard).
          if (SIN) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign OUT       = out_reg;
  assign VALID     = valid;
  assign FRAME_ERR = frame_err;
  assign OVERRUN   = overrun;
  assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_ser_to_par_rx.sv
// Directed bench for ser_to_par_rx: two instances (MSB-first and LSB-first) share stimulus.
// Honours SER_RX_PARITY_CHECK_EN by inserting the parity bit into every frame.
module tb_ser_to_par_rx;

  logic clk = 1'b0;
  logic rst_n, enable, sin, ready;
  logic [3:0] out_m, out_l;
  logic valid_m, valid_l, ferr_m, ferr_l, ovr_m, ovr_l, busy_m, busy_l;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ser_to_par_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .CLOCK(clk), .RESET_N(rst_n), .ENABLE(enable), .SIN(sin),
    .OUT(out_m), .VALID(valid_m), .READY(ready),
    .FRAME_ERR(ferr_m), .OVERRUN(ovr_m), .BUSY(busy_m)
  );

  ser_to_par_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .CLOCK(clk), .RESET_N(rst_n), .ENABLE(enable), .SIN(sin),
    .OUT(out_l), .VALID(valid_l), .READY(ready),
    .FRAME_ERR(ferr_l), .OVERRUN(ovr_l), .BUSY(busy_l)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle away from the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_bit(input logic b, input bit toggle);
    sin = b;
    if (toggle) begin
      enable = 1'b0;
      tick();
      enable = 1'b1;
    end
    tick();
  endtask

  // Start bit, data bits d[3]..d[0] in line order, then parity when compiled in.
  task automatic send_head(input logic [3:0] d, input logic par_flip, input bit toggle);
    put_bit(1'b0, toggle);
    for (int i = 3; i >= 0; i--) put_bit(d[i], toggle);
`ifdef SER_RX_PARITY_CHECK_EN
    put_bit((^d) ^ par_flip, toggle);
`else
    if (par_flip) $display("note: parity flip ignored without parity build");
`endif
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; sin = 1'b1; ready = 1'b0;
    tick(); tick();
    chk("rst_out", {12'h0, out_m}, 16'h0);
    chk("rst_valid", {15'h0, valid_m}, 16'h0);
    chk("rst_busy", {15'h0, busy_m}, 16'h0);
    chk("rst_flags", {14'h0, ferr_m, ovr_m}, 16'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", {15'h0, busy_m}, 16'h0);

    // Basic frame 1100, READY low.
    send_head(4'b1100, 1'b0, 1'b0);
    chk("f1_pre_valid", {15'h0, valid_m}, 16'h0);
    chk("f1_pre_busy", {15'h0, busy_m}, 16'h1);
    put_bit(1'b1, 1'b0);
    chk("f1_out_msb", {12'h0, out_m}, 16'hC);
    chk("f1_out_lsb", {12'h0, out_l}, 16'h3);
    chk("f1_valid", {14'h0, valid_m, valid_l}, 16'h3);
    chk("f1_busy", {15'h0, busy_m}, 16'h0);
    tick(); tick();
    chk("f1_hold_valid", {15'h0, valid_m}, 16'h1);
    chk("f1_hold_out", {12'h0, out_m}, 16'hC);
    ready = 1'b1;
    tick();
    chk("f1_taken", {15'h0, valid_m}, 16'h0);
    ready = 1'b0;

    // Overrun: two back-to-back frames with READY low.
    send_head(4'b1100, 1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    send_head(4'b1010, 1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    chk("ovr_out", {12'h0, out_m}, 16'hC);
    chk("ovr_valid", {15'h0, valid_m}, 16'h1);
    chk("ovr_pulse", {14'h0, ovr_m, ferr_m}, 16'h2);
    tick();
    chk("ovr_clear", {15'h0, ovr_m}, 16'h0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("ovr_taken", {15'h0, valid_m}, 16'h0);

    // Same pair but READY rises on the second stop edge: reload, no overrun.
    send_head(4'b1100, 1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    send_head(4'b1010, 1'b0, 1'b0);
    ready = 1'b1;
    put_bit(1'b1, 1'b0);
    ready = 1'b0;
    chk("rld_out_msb", {12'h0, out_m}, 16'hA);
    chk("rld_out_lsb", {12'h0, out_l}, 16'h5);
    chk("rld_valid", {15'h0, valid_m}, 16'h1);
    chk("rld_no_ovr", {15'h0, ovr_m}, 16'h0);
    tick();
    chk("rld_no_ovr2", {15'h0, ovr_m}, 16'h0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("rld_taken", {15'h0, valid_m}, 16'h0);

    // Framing error: stop bit 0, line held low, then released.
    send_head(4'b1100, 1'b0, 1'b0);
    put_bit(1'b0, 1'b0);
    chk("fe_pulse", {14'h0, ferr_m, ovr_m}, 16'h2);
    chk("fe_valid", {15'h0, valid_m}, 16'h0);
    chk("fe_busy", {15'h0, busy_m}, 16'h1);
    for (int i = 0; i < 5; i++) begin
      put_bit(1'b0, 1'b0);
      chk($sformatf("fe_break%0d", i), {14'h0, ferr_m, busy_m}, 16'h1);
    end
    put_bit(1'b1, 1'b0);
    chk("fe_released", {15'h0, busy_m}, 16'h0);
    send_head(4'b0101, 1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    chk("fe_next_msb", {12'h0, out_m}, 16'h5);
    chk("fe_next_lsb", {12'h0, out_l}, 16'hA);
    chk("fe_next_valid", {15'h0, valid_m}, 16'h1);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // ENABLE toggled: each bit gets one disabled edge then one enabled edge.
    send_head(4'b1100, 1'b0, 1'b1);
    sin = 1'b1;
    enable = 1'b0;
    tick();
    chk("en_pre_valid", {15'h0, valid_m}, 16'h0);
    chk("en_pre_busy", {15'h0, busy_m}, 16'h1);
    enable = 1'b1;
    tick();
    chk("en_out", {12'h0, out_m}, 16'hC);
    chk("en_valid", {15'h0, valid_m}, 16'h1);
    // Handshake completes with ENABLE low.
    enable = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    enable = 1'b1;
    chk("en_ungated_take", {15'h0, valid_m}, 16'h0);

    // Reset mid-frame while a word is held.
    send_head(4'b1010, 1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    put_bit(1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    chk("mr_pre_busy", {14'h0, busy_m, valid_m}, 16'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_out", {12'h0, out_m}, 16'h0);
    chk("mr_flags", {12'h0, valid_m, busy_m, ferr_m, ovr_m}, 16'h0);
    tick();
    rst_n = 1'b1;
    sin = 1'b1;
    tick();
    send_head(4'b1010, 1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    chk("mr_next_out", {12'h0, out_m}, 16'hA);
    chk("mr_next_valid", {15'h0, valid_m}, 16'h1);
    ready = 1'b1;
    tick();
    ready = 1'b0;

`ifdef SER_RX_PARITY_CHECK_EN
    // Parity build: wrong parity on 1100 is a framing error without a stop sample.
    send_head(4'b1100, 1'b1, 1'b0);
    chk("par_bad_fe", {14'h0, ferr_m, valid_m}, 16'h2);
    chk("par_bad_busy", {15'h0, busy_m}, 16'h1);
    put_bit(1'b1, 1'b0);
    chk("par_bad_idle", {14'h0, busy_m, valid_m}, 16'h0);
    send_head(4'b1100, 1'b0, 1'b0);
    chk("par_ok_noerr", {15'h0, ferr_m}, 16'h0);
    put_bit(1'b1, 1'b0);
    chk("par_ok_out", {12'h0, out_m}, 16'hC);
    chk("par_ok_valid", {15'h0, valid_m}, 16'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
